// File: rtl/decode_pipe_ctrl.sv
// Decode-stage pipeline controller: PC, IF/ID and ID/EX registers, decode forwarding,
// beq compare/target, and saturating stall/flush event counters.
module decode_pipe_ctrl #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_f,
  output logic [DATA_W-1:0] pc_f,
  input  logic              stall_pc,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              flush_e,
  input  logic [1:0]        fad,
  input  logic [1:0]        fbd,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] alu_out_e,
  input  logic [DATA_W-1:0] read_data_m,
  input  logic [DATA_W-1:0] alu_out_m,
  input  logic              reg_write_d,
  input  logic              mem_to_reg_d,
  input  logic              mem_write_d,
  input  logic              alu_src_d,
  input  logic              reg_dst_d,
  input  logic [2:0]        alu_ctrl_d,
  output logic [31:0]       instr_d,
  output logic [5:0]        opcode_d,
  output logic [4:0]        rs_d,
  output logic [4:0]        rt_d,
  output logic              eq_d,
  output logic              reg_write_e,
  output logic              mem_to_reg_e,
  output logic              mem_write_e,
  output logic              alu_src_e,
  output logic [2:0]        alu_ctrl_e,
  output logic [DATA_W-1:0] src_a_e,
  output logic [DATA_W-1:0] src_b_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [4:0]        rs_e,
  output logic [4:0]        rt_e,
  output logic [4:0]        rd_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [5:0] OP_BEQ = 6'b000100;

  logic [DATA_W-1:0] pc_plus4_d;
  logic [DATA_W-1:0] pc_plus4_f;
  logic [DATA_W-1:0] src_a_d;
  logic [DATA_W-1:0] src_b_d;
  logic [DATA_W-1:0] imm_d;
  logic [DATA_W-1:0] target_d;
  logic              taken_d;
  logic              stall_evt;
  logic              flush_evt;

  function automatic logic [DATA_W-1:0] fwd_mux(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] ex_alu,
    input logic [DATA_W-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_alu
  );
    case (sel)
      2'd1:    return ex_alu;
      2'd2:    return mem_rd;
      2'd3:    return mem_alu;
      default: return rf;
    endcase
  endfunction

  assign opcode_d = instr_d[31:26];
  assign rs_d     = instr_d[25:21];
  assign rt_d     = instr_d[20:16];

  assign src_a_d    = fwd_mux(fad, rd1_d, alu_out_e, read_data_m, alu_out_m);
  assign src_b_d    = fwd_mux(fbd, rd2_d, alu_out_e, read_data_m, alu_out_m);
  assign eq_d       = (src_a_d == src_b_d);
  assign imm_d      = {{(DATA_W-16){instr_d[15]}}, instr_d[15:0]};
  assign target_d   = pc_plus4_d + (imm_d << 2);
  assign pc_plus4_f = pc_f + DATA_W'(4);

  // A stalled decode stage must not redirect: its forwarded operands may still be stale.
  assign taken_d   = (opcode_d == OP_BEQ) & eq_d & ~stall_d;
  assign stall_evt = stall_pc | stall_d;
  assign flush_evt = flush_d | flush_e | taken_d;

  // NOTE: all state below uses non-blocking assignments so every register samples
  // pre-edge values; reset is sampled on the clock edge and outranks every enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_f       <= RESET_PC;
      instr_d    <= '0;
      pc_plus4_d <= '0;
    end else begin
      if (!stall_pc) pc_f <= taken_d ? target_d : pc_plus4_f;
      if (!stall_d) begin
        if (flush_d || taken_d) begin
          instr_d    <= '0;
          pc_plus4_d <= '0;
        end else begin
          instr_d    <= instr_f;
          pc_plus4_d <= pc_plus4_f;
        end
      end
    end
  end

  // ID/EX has no enable: a bubble is inserted only via flush_e.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      reg_write_e  <= 1'b0;
      mem_to_reg_e <= 1'b0;
      mem_write_e  <= 1'b0;
      alu_src_e    <= 1'b0;
      alu_ctrl_e   <= '0;
      src_a_e      <= '0;
      src_b_e      <= '0;
      imm_e        <= '0;
      rs_e         <= '0;
      rt_e         <= '0;
      rd_e         <= '0;
    end else begin
      reg_write_e  <= reg_write_d;
      mem_to_reg_e <= mem_to_reg_d;
      mem_write_e  <= mem_write_d;
      alu_src_e    <= alu_src_d;
      alu_ctrl_e   <= alu_ctrl_d;
      src_a_e      <= src_a_d;
      src_b_e      <= src_b_d;
      imm_e        <= imm_d;
      rs_e         <= instr_d[25:21];
      rt_e         <= instr_d[20:16];
      rd_e         <= reg_dst_d ? instr_d[15:11] : instr_d[20:16];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_pipe_ctrl.sv
// Directed-vector bench for decode_pipe_ctrl: fetch sequencing, forwarding compare,
// branch redirect/squash, stall/flush priority, reset during stall, counter saturation.
module tb_decode_pipe_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [31:0] I0   = 32'h0022_1820; // rs=1 rt=2 rd=3
  localparam logic [31:0] I1   = 32'h0085_3020; // rs=4 rt=5 rd=6
  localparam logic [31:0] I2   = 32'h8C43_0004;
  localparam logic [31:0] I3   = 32'hAC43_0008;
  localparam logic [31:0] BEQ  = 32'h1022_0003; // beq $1,$2,+3
  localparam logic [31:0] BEQ2 = 32'h1064_FFFE; // beq $3,$4,-2

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       instr_f;
  logic [DATA_W-1:0] pc_f;
  logic              stall_pc, stall_d, flush_d, flush_e;
  logic [1:0]        fad, fbd;
  logic [DATA_W-1:0] rd1_d, rd2_d, alu_out_e, read_data_m, alu_out_m;
  logic              reg_write_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_dst_d;
  logic [2:0]        alu_ctrl_d;
  logic [31:0]       instr_d;
  logic [5:0]        opcode_d;
  logic [4:0]        rs_d, rt_d;
  logic              eq_d;
  logic              reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e;
  logic [2:0]        alu_ctrl_e;
  logic [DATA_W-1:0] src_a_e, src_b_e, imm_e;
  logic [4:0]        rs_e, rt_e, rd_e;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_pipe_ctrl #(.DATA_W(DATA_W), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .instr_f(instr_f), .pc_f(pc_f),
    .stall_pc(stall_pc), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fad(fad), .fbd(fbd), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .alu_out_e(alu_out_e), .read_data_m(read_data_m), .alu_out_m(alu_out_m),
    .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
    .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d), .alu_ctrl_d(alu_ctrl_d),
    .instr_d(instr_d), .opcode_d(opcode_d), .rs_d(rs_d), .rt_d(rt_d), .eq_d(eq_d),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_src_e(alu_src_e), .alu_ctrl_e(alu_ctrl_e),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .imm_e(imm_e),
    .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_f = I0;
    stall_pc = 0; stall_d = 0; flush_d = 0; flush_e = 0;
    fad = 2'd0; fbd = 2'd0;
    rd1_d = 32'd5; rd2_d = 32'd5;
    alu_out_e = 32'd0; read_data_m = 32'd0; alu_out_m = 32'd0;
    reg_write_d = 1'b1; mem_to_reg_d = 1'b1; mem_write_d = 1'b1; alu_src_d = 1'b1;
    reg_dst_d = 1'b1; alu_ctrl_d = 3'b010;

    // Reset state
    step();
    check("rst_pc", pc_f, 32'h0);
    check("rst_instr_d", instr_d, 32'h0);
    check("rst_ctrl_e", {28'h0, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e}, 32'h0);
    check("rst_alu_ctrl_e", 32'(alu_ctrl_e), 32'h0);
    check("rst_src_a_e", src_a_e, 32'h0);
    check("rst_regs_e", {17'h0, rs_e, rt_e, rd_e}, 32'h0);
    check("rst_cnts", {stall_cnt, flush_cnt}, 32'h0);

    // Sequential fetch
    rst_n = 1'b1;
    step();
    check("seq_pc4", pc_f, 32'h4);
    check("seq_instr_i0", instr_d, I0);
    instr_f = I1;
    step();
    check("seq_pc8", pc_f, 32'h8);
    check("seq_instr_i1", instr_d, I1);
    check("seq_rd_e", 32'(rd_e), 32'd3);
    check("seq_rs_e", 32'(rs_e), 32'd1);
    check("seq_src_a_e", src_a_e, 32'd5);
    instr_f = I2;
    step();
    check("seq_pc12", pc_f, 32'hC);
    check("seq_instr_i2", instr_d, I2);
    check("seq_cnts", {stall_cnt, flush_cnt}, 32'h0);

    // beq $1,$2,+3 with equal operands; pc_plus4_d = 0x10
    instr_f = BEQ;
    step();
    check("beq_pc16", pc_f, 32'h10);
    check("beq_opcode_d", 32'(opcode_d), 32'h4);
    check("beq_eq", 32'(eq_d), 32'h1);
    instr_f = I3;
    step();
    check("beq_target", pc_f, 32'h1C);
    check("beq_squash", instr_d, 32'h0);
    check("beq_flush_cnt", 32'(flush_cnt), 32'd1);
    check("beq_imm_e", imm_e, 32'd3);

    // Forwarded compare: fad=0 not taken, fad=1 taken
    instr_f = BEQ2;
    step();
    check("fwd_pc20", pc_f, 32'h20);
    check("fwd_instr_beq2", instr_d, BEQ2);
    rd1_d = 32'd0; rd2_d = 32'd7; alu_out_e = 32'd7; fad = 2'd0;
    #1;
    check("fwd_eq_rf", 32'(eq_d), 32'h0);
    step();
    check("fwd_seq_pc", pc_f, 32'h24);
    check("fwd_seq_flush_cnt", 32'(flush_cnt), 32'd1);
    fad = 2'd1; instr_f = I0;
    #1;
    check("fwd_eq_ex", 32'(eq_d), 32'h1);
    step();
    check("fwd_target_neg", pc_f, 32'h1C);
    check("fwd_squash", instr_d, 32'h0);
    check("fwd_src_a_e", src_a_e, 32'd7);
    check("fwd_imm_e", imm_e, 32'hFFFF_FFFE);
    check("fwd_flush_cnt", 32'(flush_cnt), 32'd2);

    // Stall + bubble in the same cycle
    fad = 2'd0; rd1_d = 32'd1; rd2_d = 32'd2; instr_f = I1;
    step();
    check("stl_pre_pc", pc_f, 32'h20);
    stall_pc = 1; stall_d = 1; flush_e = 1; instr_f = I2;
    step();
    check("stl_pc_hold", pc_f, 32'h20);
    check("stl_instr_hold", instr_d, I1);
    check("stl_reg_write_e", 32'(reg_write_e), 32'h0);
    check("stl_rd_e", 32'(rd_e), 32'h0);
    check("stl_stall_cnt", 32'(stall_cnt), 32'd1);
    check("stl_flush_cnt", 32'(flush_cnt), 32'd3);
    stall_pc = 0; stall_d = 0; flush_e = 0;
    step();
    check("stl_rel_pc", pc_f, 32'h24);
    check("stl_rel_instr", instr_d, I2);
    check("stl_rel_reg_write_e", 32'(reg_write_e), 32'h1);
    check("stl_rel_rd_e", 32'(rd_e), 32'd6);
    check("stl_rel_alu_ctrl_e", 32'(alu_ctrl_e), 32'd2);

    // Stalled decode blocks both the redirect and flush_d
    rd1_d = 32'd5; rd2_d = 32'd5; instr_f = BEQ;
    step();
    check("sd_pc28", pc_f, 32'h28);
    stall_d = 1; flush_d = 1; instr_f = I0;
    #1;
    check("sd_eq", 32'(eq_d), 32'h1);
    step();
    check("sd_no_redirect", pc_f, 32'h2C);
    check("sd_instr_hold", instr_d, BEQ);
    check("sd_stall_cnt", 32'(stall_cnt), 32'd2);
    check("sd_flush_cnt", 32'(flush_cnt), 32'd4);
    stall_d = 0; flush_d = 0;
    step();
    check("sd_taken_pc", pc_f, 32'h34);
    check("sd_taken_squash", instr_d, 32'h0);
    check("sd_taken_flush_cnt", 32'(flush_cnt), 32'd5);

    // Reset during a held stall
    stall_pc = 1; stall_d = 1;
    step();
    check("rs_hold_pc", pc_f, 32'h34);
    check("rs_hold_stall_cnt", 32'(stall_cnt), 32'd3);
    rst_n = 1'b0;
    step();
    check("rs_pc", pc_f, 32'h0);
    check("rs_instr_d", instr_d, 32'h0);
    check("rs_ctrl_e", {28'h0, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e}, 32'h0);
    check("rs_data_e", src_a_e | src_b_e | imm_e, 32'h0);
    check("rs_regs_e", {17'h0, rs_e, rt_e, rd_e}, 32'h0);
    check("rs_cnts", {stall_cnt, flush_cnt}, 32'h0);

    // Stall counter saturation: 2^16 + 5 stalled cycles after reset
    rst_n = 1'b1;
    repeat (65534) step();
    check("sat_below", 32'(stall_cnt), 32'h0000_FFFE);
    step();
    check("sat_reach", 32'(stall_cnt), 32'h0000_FFFF);
    repeat (6) step();
    check("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
    check("sat_pc_hold", pc_f, 32'h0);
    check("sat_flush_cnt", 32'(flush_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
